dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data-cache controller between the single-cycle RISC-V core's data port and a slow handshaked main memory. Holds tag, valid and data storage, serves load hits combinationally in the same cycle, and raises `Stall` to freeze the core during refills and write-throughs. Owns all sequencing of the core↔memory data path.

---
 rtl/cache_pkg.sv | 88 ++++++++
 rtl/dcache_array.sv | 66 ++++++
 rtl/dcache_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, geometry and address helpers for the
// direct-mapped write-through data cache.
package cache_pkg;

    localparam int ADDR_W      = 12;
    localparam int OFF_W       = 4;
    localparam int DEF_INDEX_W = 5;
    localparam int DEF_TAG_W   = ADDR_W - OFF_W - DEF_INDEX_W;
    localparam int DEF_WORDS   = 4;

    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_WRITE,
        ST_WDONE
    } state_e;

    function automatic logic [1:0] addr_lane(
        input logic [ADDR_W-1:0] a
    );
        return a[1:0];
    endfunction

    function automatic logic [ADDR_W-3:0] addr_waddr(
        input logic [ADDR_W-1:0] a
    );
        return a[ADDR_W-1:2];
    endfunction

    function automatic logic [ADDR_W-5:0] addr_line(
        input logic [ADDR_W-1:0] a
    );
        return a[ADDR_W-1:4];
    endfunction

    function automatic logic [31:0] load_steer(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = '0;
        case (size)
            SZ_BYTE: r = {24'b0, word[{lane, 3'b000} +: 8]};
            SZ_HALF: r = {16'b0, word[{lane[1], 4'b0000} +: 16]};
            SZ_WORD: r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(
        input logic [1:0] lane,
        input logic [1:0] size
    );
        logic [3:0] r;
        r = '0;
        case (size)
            SZ_BYTE: r = 4'b0001 << lane;
            SZ_HALF: r = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: r = 4'b1111;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_lanes(
        input logic [31:0] wdata,
        input logic [1:0]  lane,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = '0;
        case (size)
            SZ_BYTE: r = 32'(wdata[7:0]) << {lane, 3'b000};
            SZ_HALF: r = 32'(wdata[15:0]) << {lane[1], 4'b0000};
            SZ_WORD: r = wdata;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the data cache.
// Async read port, byte-enabled sync word write, line valid control.
module dcache_array
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int WORDS   = DEF_WORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [1:0]         rd_word,
    output logic [31:0]        rd_data,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [1:0]         wr_word,
    input  logic [3:0]         wr_be,
    input  logic [31:0]        wr_data,
    input  logic [INDEX_W-1:0] line_index,
    input  logic [TAG_W-1:0]   line_tag,
    input  logic               set_valid,
    input  logic               clr_valid
);
    localparam int LINES = 1 << INDEX_W;

    logic [31:0]      data_q  [LINES][WORDS];
    logic [TAG_W-1:0] tag_q   [LINES];
    logic [LINES-1:0] valid_q;

    assign rd_data  = data_q[rd_index][rd_word];
    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];

    // Byte-enabled word write; data is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_q[wr_index][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Tag is captured when a refill completes.
    always_ff @(posedge clk) begin
        if (set_valid) begin
            tag_q[line_index] <= line_tag;
        end
    end

    // Valid bits: cleared on reset, set on refill done, dropped at refill start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[line_index] <= 1'b1;
        end else if (clr_valid) begin
            valid_q[line_index] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through no-write-allocate data cache controller.
// Sequences refills and write-throughs and stalls the core meanwhile.
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int WORDS   = DEF_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  re,
    input  logic [1:0]  we,
    input  logic [11:0] Data_addr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        Stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int         TAG_W     = ADDR_W - OFF_W - INDEX_W;
    localparam logic [1:0] LAST_WORD = 2'(WORDS - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [11:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;

    logic [ADDR_W-3:0]  look_waddr;
    logic [INDEX_W-1:0] look_index;
    logic [TAG_W-1:0]   look_tag;
    logic [1:0]         look_word;

    logic [31:0]      rd_data;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             hit;

    logic        wr_en;
    logic [1:0]  wr_word;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        set_valid;
    logic        clr_valid;

    logic idle;
    logic load_req;
    logic store_req;

    assign idle      = (state_q == ST_IDLE);
    assign load_req  = (re != SZ_NONE);
    assign store_req = (we != SZ_NONE);

    assign look_waddr = idle ? addr_waddr(Data_addr) : addr_q;
    assign look_word  = look_waddr[1:0];
    assign look_index = look_waddr[2 +: INDEX_W];
    assign look_tag   = look_waddr[ADDR_W-3 -: TAG_W];

    dcache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .WORDS   (WORDS)
    ) u_array (
        .clk        (clk),
        .rst_n      (reset),
        .rd_index   (look_index),
        .rd_word    (look_word),
        .rd_data    (rd_data),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .wr_en      (wr_en),
        .wr_index   (look_index),
        .wr_word    (wr_word),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .line_index (look_index),
        .line_tag   (look_tag),
        .set_valid  (set_valid),
        .clr_valid  (clr_valid)
    );

    assign hit = rd_valid && (rd_tag == look_tag);

    assign Rdata = (idle && load_req && !store_req && hit)
                 ? load_steer(rd_data, addr_lane(Data_addr), re)
                 : '0;

    assign Stall = (idle && ((load_req && !hit) || store_req))
                 || (state_q == ST_REFILL)
                 || (state_q == ST_WRITE);

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

    // Next-state, memory-port and array-write decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wr_en       = 1'b0;
        wr_word     = cnt_q;
        wr_be       = 4'b1111;
        wr_data     = mem_rdata;
        set_valid   = 1'b0;
        clr_valid   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (store_req) begin
                    addr_d      = addr_waddr(Data_addr);
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {addr_waddr(Data_addr), 2'b00};
                    mem_wdata_d = store_lanes(Wdata, addr_lane(Data_addr), we);
                    mem_be_d    = store_be(addr_lane(Data_addr), we);
                    state_d     = ST_WRITE;
                end else if (load_req && !hit) begin
                    addr_d     = addr_waddr(Data_addr);
                    cnt_d      = 2'd0;
                    clr_valid  = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {addr_line(Data_addr), 4'b0000};
                    state_d    = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_ack) begin
                    wr_en      = 1'b1;
                    cnt_d      = cnt_q + 2'd1;
                    mem_addr_d = {addr_q[ADDR_W-3:2], cnt_q + 2'd1, 2'b00};
                    if (cnt_q == LAST_WORD) begin
                        set_valid = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    wr_en     = hit;
                    wr_word   = look_word;
                    wr_be     = mem_be_q;
                    wr_data   = mem_wdata_q;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_WDONE;
                end
            end
            ST_WDONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, refill counter and registered memory port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a word-wide memory
// model that acks every cycle a request is outstanding.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  re;
    logic [1:0]  we;
    logic [11:0] Data_addr;
    logic [31:0] Wdata;
    logic [31:0] Rdata;
    logic        Stall;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    logic [31:0] mmem [1024];
    logic [11:0] rd_log [$];
    int          wr_cnt;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    typedef struct {
        logic [1:0]  re;
        logic [11:0] addr;
        logic [31:0] rdata;
        logic        stall;
    } vec_t;

    vec_t vecs [11];

    dcache_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .re        (re),
        .we        (we),
        .Data_addr (Data_addr),
        .Wdata     (Wdata),
        .Rdata     (Rdata),
        .Stall     (Stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_cnt = 0;
    endtask

    task automatic check_refill(input string name, input logic [11:0] base);
        check({name, "_nreads"}, 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), 32'(rd_log[i]),
                  32'(base + 12'(4 * i)));
        end
    endtask

    // Drive one core access; returns data and stall count at retirement.
    task automatic access(input logic [1:0] r, input logic [1:0] w,
                          input logic [11:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int stalls,
                          output logic req);
        bit done;
        done   = 0;
        stalls = 0;
        rd     = '0;
        req    = 1'b0;
        re = r; we = w; Data_addr = a; Wdata = d;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!Stall) begin
                rd   = Rdata;
                req  = mem_req;
                done = 1;
                break;
            end
            stalls++;
        end
        if (!done) begin
            errors++;
            $display("FAIL access_timeout: addr %h still stalled", a);
        end
        @(posedge clk);
        #1;
        re = 2'd0; we = 2'd0;
    endtask

    // Memory responder: one ack per cycle while a request is high.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    wr_cnt++;
                    wr_addr   = mem_addr;
                    wr_data   = mem_wdata;
                    wr_be     = mem_be;
                    mem_rdata = '0;
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) begin
                            mmem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                    end
                end else begin
                    rd_log.push_back(mem_addr);
                    mem_rdata = mmem[mem_addr[11:2]];
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    initial begin
        logic [31:0] rd;
        int          st;
        logic        rq;
        bit          seen;

        for (int i = 0; i < 1024; i++) begin
            mmem[i] = 32'h1000_0000 | 32'(i * 4);
        end
        mmem[12'h40] = 32'h0000_0011;
        mmem[12'h41] = 32'h0000_0022;
        mmem[12'h42] = 32'h0000_0033;
        mmem[12'h43] = 32'hAABB_CCDD;

        vecs[0]  = '{2'd3, 12'h100, 32'h0000_0011, 1'b0};
        vecs[1]  = '{2'd3, 12'h10F, 32'hAABB_CCDD, 1'b0};
        vecs[2]  = '{2'd1, 12'h10D, 32'h0000_00CC, 1'b0};
        vecs[3]  = '{2'd1, 12'h10C, 32'h0000_00DD, 1'b0};
        vecs[4]  = '{2'd1, 12'h10F, 32'h0000_00AA, 1'b0};
        vecs[5]  = '{2'd2, 12'h10E, 32'h0000_AABB, 1'b0};
        vecs[6]  = '{2'd2, 12'h10C, 32'h0000_CCDD, 1'b0};
        vecs[7]  = '{2'd2, 12'h105, 32'h0000_0022, 1'b0};
        vecs[8]  = '{2'd0, 12'h104, 32'h0000_0000, 1'b0};
        vecs[9]  = '{2'd3, 12'h504, 32'h0000_0000, 1'b1};
        vecs[10] = '{2'd3, 12'h114, 32'h0000_0000, 1'b1};

        clear_logs();
        reset = 1'b0;
        re = 2'd0; we = 2'd0; Data_addr = '0; Wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_rdata", Rdata, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        clear_logs();
        access(2'd3, 2'd0, 12'h104, 32'd0, rd, st, rq);
        check("miss_rdata", rd, 32'h0000_0022);
        check("miss_stalls", 32'(st), 32'd5);
        check_refill("miss", 12'h100);

        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            re = vecs[i].re; Data_addr = vecs[i].addr;
            #2;
            check($sformatf("vec%0d_rdata", i), Rdata, vecs[i].rdata);
            check($sformatf("vec%0d_stall", i), 32'(Stall), 32'(vecs[i].stall));
            check($sformatf("vec%0d_req", i), 32'(mem_req), 32'd0);
            re = 2'd0;
        end
        @(posedge clk);
        #1;

        clear_logs();
        access(2'd1, 2'd0, 12'h10D, 32'd0, rd, st, rq);
        check("ldb_rdata", rd, 32'h0000_00CC);
        check("ldb_stalls", 32'(st), 32'd0);
        check("ldb_req", 32'(rq), 32'd0);

        clear_logs();
        access(2'd0, 2'd2, 12'h10A, 32'h0000_BEEF, rd, st, rq);
        check("sth_stalls", 32'(st), 32'd2);
        check("sth_nwr", 32'(wr_cnt), 32'd1);
        check("sth_addr", 32'(wr_addr), 32'h108);
        check("sth_wdata", wr_data, 32'hBEEF_0000);
        check("sth_be", 32'(wr_be), 32'hC);
        check("sth_nrd", 32'(rd_log.size()), 32'd0);
        access(2'd3, 2'd0, 12'h108, 32'd0, rd, st, rq);
        check("sth_ld_rdata", rd, 32'hBEEF_0033);
        check("sth_ld_stalls", 32'(st), 32'd0);

        clear_logs();
        access(2'd0, 2'd1, 12'h101, 32'h0000_005A, rd, st, rq);
        check("stb_wdata", wr_data, 32'h0000_5A00);
        check("stb_be", 32'(wr_be), 32'h2);
        check("stb_addr", 32'(wr_addr), 32'h100);
        access(2'd3, 2'd0, 12'h100, 32'd0, rd, st, rq);
        check("stb_ld_rdata", rd, 32'h0000_5A11);

        clear_logs();
        access(2'd0, 2'd3, 12'h800, 32'hDEAD_BEEF, rd, st, rq);
        check("stw_nwr", 32'(wr_cnt), 32'd1);
        check("stw_be", 32'(wr_be), 32'hF);
        check("stw_nrd", 32'(rd_log.size()), 32'd0);
        access(2'd3, 2'd0, 12'h800, 32'd0, rd, st, rq);
        check("noalloc_stalls", 32'(st), 32'd5);
        check("noalloc_rdata", rd, 32'hDEAD_BEEF);
        check_refill("noalloc", 12'h800);

        clear_logs();
        access(2'd3, 2'd3, 12'h104, 32'h1234_5678, rd, st, rq);
        check("prio_nwr", 32'(wr_cnt), 32'd1);
        check("prio_nrd", 32'(rd_log.size()), 32'd0);
        check("prio_wdata", wr_data, 32'h1234_5678);
        check("prio_stalls", 32'(st), 32'd2);
        access(2'd3, 2'd0, 12'h104, 32'd0, rd, st, rq);
        check("prio_ld_rdata", rd, 32'h1234_5678);
        check("prio_ld_stalls", 32'(st), 32'd0);

        clear_logs();
        re = 2'd3; Data_addr = 12'h204;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rd_log.size() >= 2) begin
                seen = 1;
                break;
            end
        end
        check("rstmid_seen2", 32'(seen), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_req", 32'(mem_req), 32'd0);
        check("rstmid_addr", 32'(mem_addr), 32'd0);
        check("rstmid_be", 32'(mem_be), 32'd0);
        check("rstmid_stall_miss", 32'(Stall), 32'd1);
        re = 2'd0;
        #1;
        check("rstmid_stall", 32'(Stall), 32'd0);
        check("rstmid_rdata", Rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        access(2'd3, 2'd0, 12'h204, 32'd0, rd, st, rq);
        check("rerefill_stalls", 32'(st), 32'd5);
        check("rerefill_rdata", rd, 32'h1000_0204);
        check_refill("rerefill", 12'h200);

        clear_logs();
        access(2'd3, 2'd0, 12'h108, 32'd0, rd, st, rq);
        check("postrst_stalls", 32'(st), 32'd5);
        check("postrst_rdata", rd, 32'hBEEF_0033);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
